// File: rtl/filter_bank_xfade.sv
// Filter-output selector: routes one of N_SEL filtered streams to the codec and
// replaces hard source switches with a linear crossfade of 2^FADE_SHIFT frames.
module filter_bank_xfade #(
  parameter int DATA_W     = 32,
  parameter int CHANNELS   = 2,
  parameter int N_SEL      = 4,
  parameter int SEL_W      = 2,
  parameter int FADE_SHIFT = 5
) (
  input  logic                              AUD_BCLK,
  input  logic                              reset,
  input  logic                              AUD_DACLRCK,
  input  logic [N_SEL*CHANNELS*DATA_W-1:0]  src_in,
  input  logic [SEL_W-1:0]                  filter_choice,
  output logic [CHANNELS*DATA_W-1:0]        audio_out,
  output logic [SEL_W-1:0]                  active_sel,
  output logic                              fading
);

  localparam int M      = 1 << FADE_SHIFT;
  localparam int K_W    = FADE_SHIFT + 1;
  localparam int PROD_W = DATA_W + FADE_SHIFT + 1;
  localparam int SUM_W  = PROD_W + 1;
  localparam logic [K_W-1:0] K_ONE  = K_W'(1);
  localparam logic [K_W-1:0] K_FULL = K_W'(M);

  typedef enum logic {IDLE, FADE} state_t;

  state_t                      state, next_state;
  logic                        dac_q;
  logic                        tick;
  logic [SEL_W-1:0]            choice_s;
  logic [SEL_W-1:0]            old_sel, nxt_old, nxt_active;
  logic [K_W-1:0]              k, nxt_k;
  logic [CHANNELS*DATA_W-1:0]  nxt_audio;

  function automatic logic [DATA_W-1:0] pick(
    input logic [N_SEL*CHANNELS*DATA_W-1:0] src,
    input logic [SEL_W-1:0]                 sel,
    input int                               c
  );
    return src[(int'(sel)*CHANNELS + c)*DATA_W +: DATA_W];
  endfunction

  // Convex blend (a*(M-w) + b*w) >>> FADE_SHIFT; the guard bit keeps the sum exact.
  function automatic logic [DATA_W-1:0] mix(
    input logic [DATA_W-1:0] a,
    input logic [DATA_W-1:0] b,
    input logic [K_W-1:0]    w
  );
    logic signed [PROD_W-1:0] a_ext, b_ext, wa, wb, pa, pb;
    logic signed [SUM_W-1:0]  sum;
    a_ext = {{(PROD_W-DATA_W){a[DATA_W-1]}}, a};
    b_ext = {{(PROD_W-DATA_W){b[DATA_W-1]}}, b};
    wa    = {{(PROD_W-K_W){1'b0}}, K_FULL - w};
    wb    = {{(PROD_W-K_W){1'b0}}, w};
    pa    = a_ext * wa;
    pb    = b_ext * wb;
    sum   = {pa[PROD_W-1], pa} + {pb[PROD_W-1], pb};
    return DATA_W'(sum >>> FADE_SHIFT);
  endfunction

  assign tick = AUD_DACLRCK & ~dac_q;

  always_comb begin
    choice_s = filter_choice;
    if (int'(filter_choice) >= N_SEL) choice_s = '0;
  end

  always_ff @(posedge AUD_BCLK or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    if (tick) begin
      case (state)
        IDLE: if (choice_s != active_sel) next_state = (K_ONE >= K_FULL) ? IDLE : FADE;
        FADE: if ((k + K_ONE) >= K_FULL) next_state = IDLE;
        default: next_state = IDLE;
      endcase
    end
  end

  // The weight applied on a tick is the new k, so the switching tick already mixes.
  always_comb begin
    nxt_audio  = audio_out;
    nxt_active = active_sel;
    nxt_old    = old_sel;
    nxt_k      = k;
    fading     = (state == FADE);
    if (tick) begin
      case (state)
        IDLE: begin
          if (choice_s != active_sel) begin
            nxt_old    = active_sel;
            nxt_active = choice_s;
            nxt_k      = K_ONE;
            for (int c = 0; c < CHANNELS; c++)
              nxt_audio[c*DATA_W +: DATA_W] =
                mix(pick(src_in, active_sel, c), pick(src_in, choice_s, c), K_ONE);
          end else begin
            for (int c = 0; c < CHANNELS; c++)
              nxt_audio[c*DATA_W +: DATA_W] = pick(src_in, active_sel, c);
          end
        end
        FADE: begin
          nxt_k = k + K_ONE;
          for (int c = 0; c < CHANNELS; c++)
            nxt_audio[c*DATA_W +: DATA_W] =
              mix(pick(src_in, old_sel, c), pick(src_in, active_sel, c), k + K_ONE);
        end
        default: ;
      endcase
    end
  end

  // dac_q resets high so a frame clock already high at release is not a tick.
  always_ff @(posedge AUD_BCLK or posedge reset) begin
    if (reset) begin
      dac_q      <= 1'b1;
      audio_out  <= '0;
      active_sel <= '0;
      old_sel    <= '0;
      k          <= '0;
    end else begin
      dac_q      <= AUD_DACLRCK;
      audio_out  <= nxt_audio;
      active_sel <= nxt_active;
      old_sel    <= nxt_old;
      k          <= nxt_k;
    end
  end

endmodule
